// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state encoding, opcodes,
// datapath select encodings and the opcode-class helpers used by the FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JAL_WB    = 4'd13,
        COP0_WB   = 4'd14,
        TRAP      = 4'd15
    } ctrlStateT;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // First state after DECODE for a given opcode; unknown opcodes trap.
    function automatic ctrlStateT decodeTarget(input logic [5:0] opcode);
        ctrlStateT target;
        case (opcode)
            OP_LW, OP_SW:                     target = MEM_ADDR;
            OP_R:                             target = R_EXEC;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI:         target = I_EXEC;
            OP_BEQ, OP_BNE:                   target = BRANCH;
            OP_J:                             target = JUMP;
            OP_JAL:                           target = JAL_WB;
            OP_COP0:                          target = COP0_WB;
            default:                          target = TRAP;
        endcase
        return target;
    endfunction

    // Logical immediates use a zero-extended operand.
    function automatic logic isZeroExtOp(input logic [5:0] opcode);
        logic zext;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: zext = 1'b1;
            default:                  zext = 1'b0;
        endcase
        return zext;
    endfunction

endpackage

// File: rtl/mc_control_fsm_wait_timer.sv
// Memory-ready watchdog: counts consecutive wait cycles and flags the cycle on
// which the count would reach WAIT_MAX with memory still not ready.
module mc_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic countEn,
    input  logic clear,
    output logic timeout
);

    logic [WAIT_W-1:0] countR;

    assign timeout = countEn && (countR == WAIT_W'(WAIT_MAX - 1));

    // Consecutive wait-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countR <= '0;
        end else if (clear) begin
            countR <= '0;
        end else if (countEn) begin
            countR <= countR + WAIT_W'(1);
        end else begin
            countR <= countR;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the MIPS core (FETCH/DECODE/EXEC/MEM/WB).
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt and retired_cnt outputs.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    input  logic       stall_req,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       bne_beq,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       zero_extend,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] reg_dst,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    ctrlStateT  stateR;
    ctrlStateT  nextStateS;
    logic [5:0] opQR;
    logic       illegalOpR;
    logic       busErrR;
    logic       waitEnS;
    logic       timeoutS;

    // A stalled FETCH is not a memory wait, so it neither counts nor clears.
    assign waitEnS = ((stateR == FETCH) && !stall_req) ||
                     (stateR == MEM_READ) || (stateR == MEM_WRITE);

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) uWaitTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .countEn (waitEnS && !mem_ready),
        .clear   ((waitEnS && mem_ready) || (nextStateS != stateR)),
        .timeout (timeoutS)
    );

    // Next-state selection.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            IDLE:      nextStateS = FETCH;
            FETCH: begin
                if (stall_req)      nextStateS = FETCH;
                else if (mem_ready) nextStateS = DECODE;
                else if (timeoutS)  nextStateS = TRAP;
                else                nextStateS = FETCH;
            end
            DECODE:    nextStateS = decodeTarget(op);
            MEM_ADDR: begin
                if (opQR == OP_LW)      nextStateS = MEM_READ;
                else if (opQR == OP_SW) nextStateS = MEM_WRITE;
                else                    nextStateS = TRAP;
            end
            MEM_READ: begin
                if (mem_ready)     nextStateS = MEM_WB;
                else if (timeoutS) nextStateS = TRAP;
                else               nextStateS = MEM_READ;
            end
            MEM_WRITE: begin
                if (mem_ready)     nextStateS = FETCH;
                else if (timeoutS) nextStateS = TRAP;
                else               nextStateS = MEM_WRITE;
            end
            R_EXEC:    nextStateS = R_WB;
            I_EXEC:    nextStateS = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL_WB, COP0_WB:
                       nextStateS = FETCH;
            TRAP:      nextStateS = TRAP;
            default:   nextStateS = TRAP;
        endcase
    end

    // State, latched opcode and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR     <= IDLE;
            opQR       <= 6'd0;
            illegalOpR <= 1'b0;
            busErrR    <= 1'b0;
        end else begin
            stateR     <= nextStateS;
            opQR       <= (stateR == DECODE) ? op : opQR;
            illegalOpR <= illegalOpR | ((stateR == DECODE) && (nextStateS == TRAP));
            busErrR    <= busErrR | timeoutS;
        end
    end

    assign illegal_op = illegalOpR;
    assign bus_err    = busErrR;

    // Datapath control decode from state, latched opcode and memory handshake.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        bne_beq       = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        zero_extend   = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_b     = SRCB_REGB;
        reg_dst       = REGDST_RT;
        instr_done    = 1'b0;
        case (stateR)
            FETCH: begin
                if (!stall_req) begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end else begin
                    mem_read  = 1'b0;
                end
            end
            DECODE:    alu_src_b = SRCB_IMM_SH2;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                instr_done = 1'b1;
            end
            I_EXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_op      = ALU_IMM;
                zero_extend = isZeroExtOp(opQR);
            end
            I_WB, COP0_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                bne_beq       = (opQR == OP_BNE);
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            JAL_WB: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                instr_done = 1'b1;
            end
            default: begin
                instr_done = 1'b0;
            end
        endcase
    end

`ifdef MC_PERF_CNT_EN
    // Activity counters; both wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            retired_cnt <= 32'd0;
        end else begin
            if ((stateR != IDLE) && (stateR != TRAP)) cycle_cnt <= cycle_cnt + 32'd1;
            else                                      cycle_cnt <= cycle_cnt;
            if (instr_done) retired_cnt <= retired_cnt + 32'd1;
            else            retired_cnt <= retired_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm with hand-derived control vectors.
module tb_mc_control_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_COP0 = 6'b010000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // ctrl = {pc_write, pc_write_cond, bne_beq, i_or_d, mem_read, mem_write, ir_write,
    //         mem_to_reg, alu_src_a, reg_write, zero_extend, pc_source, alu_op, alu_src_b, reg_dst, instr_done}
    localparam logic [19:0] B_PCW  = 20'h80000;
    localparam logic [19:0] B_PCWC = 20'h40000;
    localparam logic [19:0] B_BNB  = 20'h20000;
    localparam logic [19:0] B_IOD  = 20'h10000;
    localparam logic [19:0] B_MR   = 20'h08000;
    localparam logic [19:0] B_MW   = 20'h04000;
    localparam logic [19:0] B_IRW  = 20'h02000;
    localparam logic [19:0] B_M2R  = 20'h01000;
    localparam logic [19:0] B_ASA  = 20'h00800;
    localparam logic [19:0] B_RW   = 20'h00400;
    localparam logic [19:0] B_ZE   = 20'h00200;
    localparam logic [19:0] PCS_AO = 20'h00080;
    localparam logic [19:0] PCS_J  = 20'h00100;
    localparam logic [19:0] AOP_SB = 20'h00020;
    localparam logic [19:0] AOP_FN = 20'h00040;
    localparam logic [19:0] AOP_IM = 20'h00060;
    localparam logic [19:0] ASB_4  = 20'h00008;
    localparam logic [19:0] ASB_I  = 20'h00010;
    localparam logic [19:0] ASB_I2 = 20'h00018;
    localparam logic [19:0] RD_RD  = 20'h00002;
    localparam logic [19:0] RD_31  = 20'h00004;
    localparam logic [19:0] B_DONE = 20'h00001;

    localparam logic [19:0] E_ZERO  = 20'h00000;
    localparam logic [19:0] E_FRDY  = B_PCW | B_MR | B_IRW | ASB_4;
    localparam logic [19:0] E_FWAIT = B_MR | ASB_4;
    localparam logic [19:0] E_DEC   = ASB_I2;
    localparam logic [19:0] E_MADDR = B_ASA | ASB_I;
    localparam logic [19:0] E_MREAD = B_IOD | B_MR;
    localparam logic [19:0] E_MWB   = B_RW | B_M2R | B_DONE;
    localparam logic [19:0] E_MWRW  = B_IOD | B_MW;
    localparam logic [19:0] E_MWRR  = B_IOD | B_MW | B_DONE;
    localparam logic [19:0] E_REX   = B_ASA | AOP_FN;
    localparam logic [19:0] E_RWB   = B_RW | RD_RD | B_DONE;
    localparam logic [19:0] E_IEXZ  = B_ASA | B_ZE | AOP_IM | ASB_I;
    localparam logic [19:0] E_IEXS  = B_ASA | AOP_IM | ASB_I;
    localparam logic [19:0] E_IWB   = B_RW | B_DONE;
    localparam logic [19:0] E_BNE   = B_PCWC | B_BNB | B_ASA | PCS_AO | AOP_SB | B_DONE;
    localparam logic [19:0] E_BEQ   = B_PCWC | B_ASA | PCS_AO | AOP_SB | B_DONE;
    localparam logic [19:0] E_JMP   = B_PCW | PCS_J | B_DONE;
    localparam logic [19:0] E_JAL   = B_PCW | B_RW | PCS_J | RD_31 | B_DONE;
    localparam logic [19:0] E_COP0  = B_RW | B_DONE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       stall_req = 1'b0;
    logic       pc_write, pc_write_cond, bne_beq, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, alu_src_a, reg_write, zero_extend, instr_done, illegal_op, bus_err;
    logic [1:0] pc_source, alu_op, alu_src_b, reg_dst;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif
    logic [19:0] ctrl;
    int errors = 0;
    int checks = 0;

    assign ctrl = {pc_write, pc_write_cond, bne_beq, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, alu_src_a, reg_write, zero_extend, pc_source, alu_op,
                   alu_src_b, reg_dst, instr_done};

    always #5 clk = ~clk;

    mc_control_fsm #(.WAIT_MAX(15), .WAIT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .mem_ready     (mem_ready),
        .stall_req     (stall_req),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .bne_beq       (bne_beq),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .reg_write     (reg_write),
        .zero_extend   (zero_extend),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .reg_dst       (reg_dst),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .bus_err       (bus_err)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .retired_cnt   (retired_cnt)
`endif
    );

    // Pulse reset; returns at posedge+1 with the FSM in IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ctrl !== E_ZERO) begin
            errors++; $display("FAIL reset_ctrl: got %h expected %h", ctrl, E_ZERO);
        end
        checks++;
        if ({illegal_op, bus_err} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b expected 00", {illegal_op, bus_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [19:0] ev [6];
        ev = '{E_ZERO, E_FRDY, E_DEC, E_MADDR, E_MREAD, E_MWB};
        op = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); checks++;
            if (ctrl !== ev[i]) begin
                errors++; $display("FAIL lw[%0d]: got %h expected %h", i, ctrl, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [19:0] ev [6];
        logic [5:0]  ov [6];
        ev = '{E_FRDY, E_DEC, E_BNE, E_FRDY, E_DEC, E_BEQ};
        ov = '{OP_BNE, OP_BNE, OP_BNE, OP_BEQ, OP_BEQ, OP_BEQ};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = ov[i];
            @(negedge clk); checks++;
            if (ctrl !== ev[i]) begin
                errors++; $display("FAIL branch[%0d]: got %h expected %h", i, ctrl, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_itype();
        logic [19:0] ev [8];
        logic [5:0]  ov [8];
        ev = '{E_FRDY, E_DEC, E_IEXZ, E_IWB, E_FRDY, E_DEC, E_IEXS, E_IWB};
        ov = '{OP_ORI, OP_ORI, OP_ORI, OP_ORI, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = ov[i];
            @(negedge clk); checks++;
            if (ctrl !== ev[i]) begin
                errors++; $display("FAIL itype[%0d]: got %h expected %h", i, ctrl, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] ev [13];
        logic [5:0]  ov [13];
        ev = '{E_FRDY, E_DEC, E_JMP, E_FRDY, E_DEC, E_JAL, E_FRDY, E_DEC, E_COP0,
               E_FRDY, E_DEC, E_IEXZ, E_IWB};
        ov = '{OP_J, OP_J, OP_J, OP_JAL, OP_JAL, OP_JAL, OP_COP0, OP_COP0, OP_COP0,
               OP_XORI, OP_XORI, OP_XORI, OP_XORI};
        mem_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            op = ov[i];
            @(negedge clk); checks++;
            if (ctrl !== ev[i]) begin
                errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, ctrl, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        logic [19:0] ev [8];
        logic        rv [8];
        ev = '{E_FRDY, E_DEC, E_MADDR, E_MWRW, E_MWRW, E_MWRW, E_MWRR, E_FRDY};
        rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op = OP_SW;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rv[i];
            @(negedge clk); checks++;
            if (ctrl !== ev[i]) begin
                errors++; $display("FAIL sw_wait[%0d]: got %h expected %h", i, ctrl, ev[i]);
            end
            @(posedge clk); #1;
        end
        // Last checked cycle was FETCH -> DECODE; finish the SW so the next test starts in FETCH.
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_stall();
        logic [19:0] ev [6];
        logic        sv [6];
        ev = '{E_ZERO, E_ZERO, E_FRDY, E_DEC, E_REX, E_RWB};
        sv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        op = OP_R; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stall_req = sv[i];
            @(negedge clk); checks++;
            if (ctrl !== ev[i]) begin
                errors++; $display("FAIL stall[%0d]: got %h expected %h", i, ctrl, ev[i]);
            end
            @(posedge clk); #1;
        end
        stall_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [19:0] ev [6];
        op = OP_LW; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk); checks++;
        if (ctrl !== E_MREAD) begin
            errors++; $display("FAIL rstmid_memread: got %h expected %h", ctrl, E_MREAD);
        end
        #1 rst_n = 1'b0;
        #1; checks++;
        if (ctrl !== E_ZERO) begin
            errors++; $display("FAIL rstmid_zero: got %h expected %h", ctrl, E_ZERO);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b1;
        ev = '{E_ZERO, E_FRDY, E_DEC, E_MADDR, E_MREAD, E_MWB};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); checks++;
            if (ctrl !== ev[i]) begin
                errors++; $display("FAIL rstmid_after[%0d]: got %h expected %h", i, ctrl, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_boundary();
        op = OP_R;
        for (int i = 0; i < 18; i++) begin
            logic [19:0] e;
            mem_ready = (i >= 14) ? 1'b1 : 1'b0;
            e = (i < 14) ? E_FWAIT : (i == 14) ? E_FRDY : (i == 15) ? E_DEC : (i == 16) ? E_REX : E_RWB;
            @(negedge clk); checks++;
            if (ctrl !== e) begin
                errors++; $display("FAIL wait_bound[%0d]: got %h expected %h", i, ctrl, e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus_err !== 1'b0) begin
            errors++; $display("FAIL wait_bound_buserr: got %b expected 0", bus_err);
        end
    endtask

    task automatic test_bus_err();
        mem_ready = 1'b0; op = OP_LW;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); checks++;
            if (ctrl !== E_FWAIT || bus_err !== 1'b0) begin
                errors++; $display("FAIL buserr_wait[%0d]: got %h/%b expected %h/0", i, ctrl, bus_err, E_FWAIT);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); checks++;
            if (ctrl !== E_ZERO || {illegal_op, bus_err} !== 2'b01) begin
                errors++; $display("FAIL buserr_trap[%0d]: got %h/%b expected %h/01", i, ctrl, {illegal_op, bus_err}, E_ZERO);
            end
            mem_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [19:0] ev [5];
        do_reset();
        checks++;
        if ({illegal_op, bus_err} !== 2'b00) begin
            errors++; $display("FAIL illegal_flags_cleared: got %b expected 00", {illegal_op, bus_err});
        end
        ev = '{E_ZERO, E_FRDY, E_DEC, E_ZERO, E_ZERO};
        op = OP_BAD; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); checks++;
            if (ctrl !== ev[i]) begin
                errors++; $display("FAIL illegal[%0d]: got %h expected %h", i, ctrl, ev[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({illegal_op, bus_err} !== 2'b10) begin
            errors++; $display("FAIL illegal_flag: got %b expected 10", {illegal_op, bus_err});
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_itype();
        test_back_to_back();
        test_sw_wait();
        test_stall();
        test_reset_mid();
        test_wait_boundary();
        test_bus_err();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
